// File: rtl/vga_pkg.sv
// Shared framebuffer geometry and fill FSM encoding for the vmem write path.
// Contents:
//   H_RES, V_RES, PIXEL_COUNT  framebuffer geometry (row pitch, lines, total pixels)
//   PIX_W                      RGB332 pixel width
//   fill_state_t               rectangle-fill FSM state encoding
package vga_pkg;

    localparam int H_RES       = 640;
    localparam int V_RES       = 400;
    localparam int PIXEL_COUNT = H_RES * V_RES;
    localparam int PIX_W       = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } fill_state_t;

endpackage

// File: rtl/vmem_rect_walker.sv
// Address walker for a clipped rectangle. Loads base/width/height, then steps
// column-major-within-row through every pixel address of the rectangle, one
// step per asserted advance. While advance is low all counters hold.
// Ports:
//   cpu_clk   in   clock
//   reset     in   synchronous active-high reset
//   load      in   latch base and clipped size, restart at the top-left pixel
//   advance   in   step to the next pixel
//   base      in   32  address of the top-left pixel
//   w_clip    in   10  clipped width (non-zero when a walk follows)
//   h_clip    in   10  clipped height (non-zero when a walk follows)
//   cur_addr  out  32  address of the current pixel
//   last_pix  out  1   current pixel is the bottom-right one
module vmem_rect_walker
    import vga_pkg::*;
(
    input  logic        cpu_clk,
    input  logic        reset,
    input  logic        load,
    input  logic        advance,
    input  logic [31:0] base,
    input  logic [9:0]  w_clip,
    input  logic [9:0]  h_clip,
    output logic [31:0] cur_addr,
    output logic        last_pix
);

    logic [9:0]  col;
    logic [9:0]  row;
    logic [9:0]  col_last;
    logic [9:0]  row_last;
    logic [31:0] row_base;
    logic [31:0] cur;

    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            col      <= '0;
            row      <= '0;
            col_last <= '0;
            row_last <= '0;
            row_base <= '0;
            cur      <= '0;
        end else if (load) begin
            col      <= '0;
            row      <= '0;
            col_last <= w_clip - 10'd1;
            row_last <= h_clip - 10'd1;
            row_base <= base;
            cur      <= base;
        end else if (advance) begin
            if (col == col_last) begin
                // End of a row: jump to the start of the next line.
                col      <= '0;
                row      <= row + 10'd1;
                row_base <= row_base + 32'(H_RES);
                cur      <= row_base + 32'(H_RES);
            end else begin
                col <= col + 10'd1;
                cur <= cur + 32'd1;
            end
        end
    end

    assign cur_addr = cur;
    assign last_pix = (col == col_last) && (row == row_last);

endmodule

// File: rtl/vmem_fill_arbiter.sv
// Single write master for the 640x400 RGB332 framebuffer. CPU pixel writes
// pass straight through (one cycle latency) and always win; a rectangle fill
// engine uses the cycles in which the CPU is not writing.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for fill_start; parameters latched on the pulse
// SETUP | clip rectangle to the screen, compute base, load walker
// RUN   | emit one fill pixel per cycle without cpu_wr
// DONE  | fill_done pulse, back to IDLE next cycle
//
// Ports:
//   cpu_clk, reset                          clock, synchronous active-high reset
//   cpu_wr, cpu_addr, cpu_data              CPU pixel write
//   fill_start, fill_x/y/w/h, fill_color    fill request
//   fill_busy, fill_done                    fill status
//   vm_wr, vm_addr, vm_data                 registered framebuffer write port
module vmem_fill_arbiter
    import vga_pkg::*;
(
    input  logic             cpu_clk,
    input  logic             reset,
    input  logic             cpu_wr,
    input  logic [31:0]      cpu_addr,
    input  logic [PIX_W-1:0] cpu_data,
    input  logic             fill_start,
    input  logic [9:0]       fill_x,
    input  logic [9:0]       fill_y,
    input  logic [9:0]       fill_w,
    input  logic [9:0]       fill_h,
    input  logic [PIX_W-1:0] fill_color,
    output logic             fill_busy,
    output logic             fill_done,
    output logic             vm_wr,
    output logic [31:0]      vm_addr,
    output logic [PIX_W-1:0] vm_data
);

    fill_state_t state, state_nxt;

    logic [9:0]       fx, fy, fw, fh;
    logic [PIX_W-1:0] fcolor;

    logic [10:0] rem_w, rem_h;
    logic [9:0]  w_clip, h_clip;
    logic        rect_empty;
    logic [31:0] base;
    logic [31:0] cur_addr;
    logic        last_pix;
    logic        cpu_ok;
    logic        fill_go;

    // Clipping arithmetic is only meaningful when the origin is on screen;
    // otherwise rect_empty routes the fill straight to DONE.
    always_comb begin
        rem_w      = 11'(H_RES) - {1'b0, fx};
        rem_h      = 11'(V_RES) - {1'b0, fy};
        w_clip     = ({1'b0, fw} < rem_w) ? fw : rem_w[9:0];
        h_clip     = ({1'b0, fh} < rem_h) ? fh : rem_h[9:0];
        rect_empty = ({1'b0, fx} >= 11'(H_RES)) || ({1'b0, fy} >= 11'(V_RES))
                     || (fw == 10'd0) || (fh == 10'd0);
        // y*640 as shifts: 640 = 512 + 128.
        base       = ({22'd0, fy} << 9) + ({22'd0, fy} << 7) + {22'd0, fx};
    end

    assign cpu_ok  = cpu_wr && (cpu_addr < 32'(PIXEL_COUNT));
    // Any CPU strobe, even an out-of-range one, takes the cycle from the fill.
    assign fill_go = (state == S_RUN) && !cpu_wr;

    vmem_rect_walker u_walker (
        .cpu_clk  (cpu_clk),
        .reset    (reset),
        .load     (state == S_SETUP),
        .advance  (fill_go),
        .base     (base),
        .w_clip   (w_clip),
        .h_clip   (h_clip),
        .cur_addr (cur_addr),
        .last_pix (last_pix)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (fill_start) state_nxt = S_SETUP;
            S_SETUP: state_nxt = rect_empty ? S_DONE : S_RUN;
            S_RUN:   if (fill_go && last_pix) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            state   <= S_IDLE;
            fx      <= '0;
            fy      <= '0;
            fw      <= '0;
            fh      <= '0;
            fcolor  <= '0;
            vm_wr   <= 1'b0;
            vm_addr <= '0;
            vm_data <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && fill_start) begin
                fx     <= fill_x;
                fy     <= fill_y;
                fw     <= fill_w;
                fh     <= fill_h;
                fcolor <= fill_color;
            end
            vm_wr <= cpu_ok || fill_go;
            if (cpu_ok) begin
                vm_addr <= cpu_addr;
                vm_data <= cpu_data;
            end else if (fill_go) begin
                vm_addr <= cur_addr;
                vm_data <= fcolor;
            end
        end
    end

    assign fill_busy = (state != S_IDLE);
    assign fill_done = (state == S_DONE);

endmodule

// File: tb/tb_vmem_fill_arbiter.sv
module tb_vmem_fill_arbiter;

    logic        cpu_clk = 1'b0;
    logic        reset;
    logic        cpu_wr;
    logic [31:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        fill_start;
    logic [9:0]  fill_x, fill_y, fill_w, fill_h;
    logic [7:0]  fill_color;
    logic        fill_busy, fill_done, vm_wr;
    logic [31:0] vm_addr;
    logic [7:0]  vm_data;

    int checks   = 0;
    int failures = 0;

    logic [31:0] wa[$];
    logic [7:0]  wd[$];
    int          done_cnt;
    int          done_at;

    vmem_fill_arbiter dut (
        .cpu_clk    (cpu_clk),
        .reset      (reset),
        .cpu_wr     (cpu_wr),
        .cpu_addr   (cpu_addr),
        .cpu_data   (cpu_data),
        .fill_start (fill_start),
        .fill_x     (fill_x),
        .fill_y     (fill_y),
        .fill_w     (fill_w),
        .fill_h     (fill_h),
        .fill_color (fill_color),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .vm_wr      (vm_wr),
        .vm_addr    (vm_addr),
        .vm_data    (vm_data)
    );

    always #5 cpu_clk = ~cpu_clk;

    // Write/done log, sampled mid-cycle.
    always @(negedge cpu_clk) begin
        if (vm_wr) begin
            wa.push_back(vm_addr);
            wd.push_back(vm_data);
        end
        if (fill_done) begin
            done_cnt = done_cnt + 1;
            done_at  = wa.size();
        end
    end

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        done_cnt = 0;
        done_at  = -1;
    endtask

    task automatic start_fill(input logic [9:0] x, input logic [9:0] y,
                              input logic [9:0] w, input logic [9:0] h,
                              input logic [7:0] c);
        fill_x = x; fill_y = y; fill_w = w; fill_h = h; fill_color = c;
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (vm_wr !== 1'b0 || fill_busy !== 1'b0 || fill_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got wr=%b busy=%b done=%b, want 0 0 0", vm_wr, fill_busy, fill_done);
        end
        checks++;
        if (vm_addr !== 32'd0 || vm_data !== 8'd0) begin
            failures++;
            $display("FAIL reset_bus: got addr=%0d data=%h, want 0 00", vm_addr, vm_data);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_cpu_pass();
        cpu_wr = 1'b1; cpu_addr = 32'd5; cpu_data = 8'hE0;
        tick();
        cpu_wr = 1'b0;
        checks++;
        if (vm_wr !== 1'b1 || vm_addr !== 32'd5 || vm_data !== 8'hE0) begin
            failures++;
            $display("FAIL cpu_pass: got wr=%b addr=%0d data=%h, want 1 5 e0", vm_wr, vm_addr, vm_data);
        end
        cpu_wr = 1'b1; cpu_addr = 32'd255999; cpu_data = 8'h03;
        tick();
        cpu_wr = 1'b0;
        checks++;
        if (vm_wr !== 1'b1 || vm_addr !== 32'd255999 || vm_data !== 8'h03) begin
            failures++;
            $display("FAIL cpu_last_addr: got wr=%b addr=%0d data=%h, want 1 255999 03", vm_wr, vm_addr, vm_data);
        end
        tick();
        checks++;
        if (vm_wr !== 1'b0) begin
            failures++;
            $display("FAIL cpu_idle: got wr=%b, want 0", vm_wr);
        end
    endtask

    task automatic test_cpu_oob();
        cpu_wr = 1'b1; cpu_addr = 32'd256000; cpu_data = 8'hFF;
        tick();
        cpu_wr = 1'b0;
        checks++;
        if (vm_wr !== 1'b0) begin
            failures++;
            $display("FAIL cpu_oob: got wr=%b, want 0", vm_wr);
        end
        tick();
    endtask

    task automatic test_fill_basic();
        logic [31:0] exp_a[6];
        exp_a = '{32'd642, 32'd643, 32'd644, 32'd1282, 32'd1283, 32'd1284};
        clear_log();
        start_fill(10'd2, 10'd1, 10'd3, 10'd2, 8'h1C);
        checks++;
        if (fill_busy !== 1'b1) begin
            failures++;
            $display("FAIL fill_busy_start: got %b, want 1", fill_busy);
        end
        tick(); tick(); tick();
        // A start while busy must be ignored.
        start_fill(10'd0, 10'd0, 10'd1, 10'd1, 8'hFF);
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (wa.size() !== 6) begin
            failures++;
            $display("FAIL fill_basic_count: got %0d writes, want 6", wa.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (wa[i] !== exp_a[i] || wd[i] !== 8'h1C) begin
                    failures++;
                    $display("FAIL fill_basic_pix%0d: got addr=%0d data=%h, want %0d 1c", i, wa[i], wd[i], exp_a[i]);
                end
            end
        end
        checks++;
        if (done_cnt !== 1 || done_at !== 6) begin
            failures++;
            $display("FAIL fill_basic_done: got pulses=%0d at_write=%0d, want 1 at 6", done_cnt, done_at);
        end
        checks++;
        if (fill_busy !== 1'b0) begin
            failures++;
            $display("FAIL fill_busy_end: got %b, want 0", fill_busy);
        end
    endtask

    task automatic test_fill_clip();
        clear_log();
        start_fill(10'd638, 10'd399, 10'd10, 10'd10, 8'h55);
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (wa.size() !== 2) begin
            failures++;
            $display("FAIL fill_clip_count: got %0d writes, want 2", wa.size());
        end else begin
            checks++;
            if (wa[0] !== 32'd255998 || wa[1] !== 32'd255999 || wd[0] !== 8'h55 || wd[1] !== 8'h55) begin
                failures++;
                $display("FAIL fill_clip_addr: got %0d/%h %0d/%h, want 255998/55 255999/55", wa[0], wd[0], wa[1], wd[1]);
            end
        end
        checks++;
        if (done_cnt !== 1 || done_at !== 2) begin
            failures++;
            $display("FAIL fill_clip_done: got pulses=%0d at_write=%0d, want 1 at 2", done_cnt, done_at);
        end
    endtask

    task automatic test_cpu_priority();
        logic [31:0] exp_a[6];
        logic [7:0]  exp_d[6];
        exp_a = '{32'd1290, 32'd100, 32'd200, 32'd1291, 32'd1292, 32'd1293};
        exp_d = '{8'hA5, 8'h11, 8'h22, 8'hA5, 8'hA5, 8'hA5};
        clear_log();
        start_fill(10'd10, 10'd2, 10'd4, 10'd1, 8'hA5);  // edge 0
        tick();                                          // edge 1: SETUP
        tick();                                          // edge 2: pixel 0
        cpu_wr = 1'b1; cpu_addr = 32'd100; cpu_data = 8'h11;
        tick();
        cpu_addr = 32'd200; cpu_data = 8'h22;
        tick();
        cpu_wr = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (wa.size() !== 6) begin
            failures++;
            $display("FAIL prio_count: got %0d writes, want 6", wa.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (wa[i] !== exp_a[i] || wd[i] !== exp_d[i]) begin
                    failures++;
                    $display("FAIL prio_seq%0d: got addr=%0d data=%h, want %0d %h", i, wa[i], wd[i], exp_a[i], exp_d[i]);
                end
            end
        end
        checks++;
        if (done_cnt !== 1 || done_at !== 6) begin
            failures++;
            $display("FAIL prio_done: got pulses=%0d at_write=%0d, want 1 at 6", done_cnt, done_at);
        end
    endtask

    task automatic test_reset_mid_fill();
        clear_log();
        start_fill(10'd0, 10'd0, 10'd20, 10'd5, 8'h77);
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        tick();
        checks++;
        if (vm_wr !== 1'b0 || fill_busy !== 1'b0) begin
            failures++;
            $display("FAIL midreset_state: got wr=%b busy=%b, want 0 0", vm_wr, fill_busy);
        end
        reset = 1'b0;
        clear_log();
        for (int i = 0; i < 15; i++) tick();
        checks++;
        if (done_cnt !== 0 || wa.size() !== 0) begin
            failures++;
            $display("FAIL midreset_quiet: got pulses=%0d writes=%0d, want 0 0", done_cnt, wa.size());
        end
    endtask

    task automatic test_empty_fills();
        clear_log();
        start_fill(10'd5, 10'd5, 10'd0, 10'd3, 8'h12);
        tick();
        checks++;
        if (fill_done !== 1'b1) begin
            failures++;
            $display("FAIL empty_w_timing: got done=%b two edges after start, want 1", fill_done);
        end
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (done_cnt !== 1 || wa.size() !== 0) begin
            failures++;
            $display("FAIL empty_w: got pulses=%0d writes=%0d, want 1 0", done_cnt, wa.size());
        end
        clear_log();
        start_fill(10'd640, 10'd0, 10'd5, 10'd5, 8'h12);
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (done_cnt !== 1 || wa.size() !== 0) begin
            failures++;
            $display("FAIL empty_x: got pulses=%0d writes=%0d, want 1 0", done_cnt, wa.size());
        end
        clear_log();
        start_fill(10'd0, 10'd400, 10'd5, 10'd5, 8'h12);
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (done_cnt !== 1 || wa.size() !== 0) begin
            failures++;
            $display("FAIL empty_y: got pulses=%0d writes=%0d, want 1 0", done_cnt, wa.size());
        end
    endtask

    task automatic test_back_to_back();
        clear_log();
        start_fill(10'd3, 10'd0, 10'd1, 10'd1, 8'h01);  // edge 0
        tick();                                        // edge 1: SETUP
        tick();                                        // edge 2: write, -> DONE
        start_fill(10'd7, 10'd0, 10'd1, 10'd1, 8'h02);  // edge 3: in DONE, ignored
        start_fill(10'd9, 10'd1, 10'd1, 10'd1, 8'h03);  // edge 4: IDLE, accepted
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (wa.size() !== 2) begin
            failures++;
            $display("FAIL b2b_count: got %0d writes, want 2", wa.size());
        end else begin
            checks++;
            if (wa[0] !== 32'd3 || wd[0] !== 8'h01 || wa[1] !== 32'd649 || wd[1] !== 8'h03) begin
                failures++;
                $display("FAIL b2b_seq: got %0d/%h %0d/%h, want 3/01 649/03", wa[0], wd[0], wa[1], wd[1]);
            end
        end
        checks++;
        if (done_cnt !== 2) begin
            failures++;
            $display("FAIL b2b_done: got pulses=%0d, want 2", done_cnt);
        end
    endtask

    initial begin
        reset = 1'b1; cpu_wr = 1'b0; cpu_addr = '0; cpu_data = '0;
        fill_start = 1'b0; fill_x = '0; fill_y = '0; fill_w = '0; fill_h = '0;
        fill_color = '0;
        done_cnt = 0; done_at = -1;
        test_reset();
        test_cpu_pass();
        test_cpu_oob();
        test_fill_basic();
        test_fill_clip();
        test_cpu_priority();
        test_reset_mid_fill();
        test_empty_fills();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
